// File: rtl/alu_cofactor_pair.sv
// alu_cofactor_pair: pairs orig/dup amplitudes, emits r1=p1+p2 then r2=p1-p2; r1 two cycles after orig accept.
// Results buffered against out_ready stalls; in_ready low in S_OUT0, follows out_ready in S_OUT1. COFACTOR_SAT_EN selects saturation.
module alu_cofactor_pair #(
  parameter int complex_bit = 24,
  parameter int num_qubit   = 3,
  parameter int tq_w        = (num_qubit > 1) ? $clog2(num_qubit) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [tq_w-1:0]          toggle_qubit,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [num_qubit-1:0]     in_location,
  input  logic [7:0]               in_alpha,
  input  logic [2*complex_bit-1:0] in_amplitude,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [num_qubit-1:0]     out_location,
  output logic [2*complex_bit-1:0] out_amplitude,
  output logic                     out_first,
  output logic                     pair_error,
  output logic                     overflow,
  output logic [15:0]              pair_count
);

  localparam int CB = complex_bit;
  localparam int W1 = CB + 1;
  localparam int W2 = CB + 2;

  typedef enum logic [1:0] {S_ORIG, S_DUP, S_OUT0, S_OUT1} state_t;
  state_t state, state_nx;

  function automatic logic fits(input logic signed [W2-1:0] v);
    fits = (v[W2-1:CB-1] == '0) || (v[W2-1:CB-1] == '1);
  endfunction

  function automatic logic signed [CB-1:0] reduce(input logic signed [W2-1:0] v);
`ifdef COFACTOR_SAT_EN
    if (!fits(v))
      reduce = v[W2-1] ? {1'b1, {(CB-1){1'b0}}} : {1'b0, {(CB-1){1'b1}}};
    else
      reduce = v[CB-1:0];
`else
    reduce = v[CB-1:0];
`endif
  endfunction

  logic [num_qubit-1:0] loc1, loc2, pair_mask;
  logic signed [CB-1:0] p1_re, p1_im, r2_re, r2_im;
  logic signed [CB-1:0] a_re, a_im, p_re, p_im;
  logic signed [W1-1:0] re_x, im_x, pr_f, pi_f;
  logic signed [W2-1:0] s_re, s_im, d_re, d_im;
  logic                 p_ovf, sum_ovf, pair_ok, in_fire;
  logic                 unused_alpha;

  assign unused_alpha = ^in_alpha[7:3];
  assign pair_mask    = num_qubit'(1) << toggle_qubit;
  assign pair_ok      = (in_location == (loc1 ^ pair_mask));
  assign in_fire      = in_valid & in_ready;
  assign out_first    = (state == S_OUT0);

  // Product i^k * a, negations carried one bit wider so -min is exact before reduction
  always_comb begin
    a_re = in_amplitude[2*CB-1:CB];
    a_im = in_amplitude[CB-1:0];
    re_x = {a_re[CB-1], a_re};
    im_x = {a_im[CB-1], a_im};
    pr_f = re_x;
    pi_f = im_x;
    case (in_alpha[1:0])
      2'd1:    begin pr_f = -im_x; pi_f = re_x;  end
      2'd2:    begin pr_f = -re_x; pi_f = -im_x; end
      2'd3:    begin pr_f = im_x;  pi_f = -re_x; end
      default: begin pr_f = re_x;  pi_f = im_x;  end
    endcase
    if (in_alpha[2]) begin
      pr_f = '0;
      pi_f = '0;
    end
    p_ovf = !fits({pr_f[W1-1], pr_f}) || !fits({pi_f[W1-1], pi_f});
    p_re  = reduce({pr_f[W1-1], pr_f});
    p_im  = reduce({pi_f[W1-1], pi_f});
  end

  always_comb begin
    s_re = {{2{p1_re[CB-1]}}, p1_re} + {{2{p_re[CB-1]}}, p_re};
    s_im = {{2{p1_im[CB-1]}}, p1_im} + {{2{p_im[CB-1]}}, p_im};
    d_re = {{2{p1_re[CB-1]}}, p1_re} - {{2{p_re[CB-1]}}, p_re};
    d_im = {{2{p1_im[CB-1]}}, p1_im} - {{2{p_im[CB-1]}}, p_im};
    sum_ovf = !fits(s_re) || !fits(s_im) || !fits(d_re) || !fits(d_im);
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_ORIG: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_DUP;
      end
      S_DUP: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = pair_ok ? S_OUT0 : S_ORIG;
      end
      S_OUT0: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_OUT1;
      end
      S_OUT1: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nx = in_valid ? S_DUP : S_ORIG;
      end
      default: state_nx = S_ORIG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_ORIG;
      loc1          <= '0;
      loc2          <= '0;
      p1_re         <= '0;
      p1_im         <= '0;
      r2_re         <= '0;
      r2_im         <= '0;
      out_location  <= '0;
      out_amplitude <= '0;
      pair_error    <= 1'b0;
      overflow      <= 1'b0;
      pair_count    <= '0;
    end else begin
      state <= state_nx;
      // S_OUT1 accepts count as originals since they overlap the r2 handshake
      if (in_fire && (state == S_ORIG || state == S_OUT1)) begin
        loc1  <= in_location;
        p1_re <= p_re;
        p1_im <= p_im;
        if (p_ovf) overflow <= 1'b1;
      end
      if (in_fire && state == S_DUP) begin
        if (p_ovf) overflow <= 1'b1;
        if (!pair_ok) begin
          pair_error <= 1'b1;
        end else begin
          if (sum_ovf) overflow <= 1'b1;
          out_location  <= loc1;
          out_amplitude <= {reduce(s_re), reduce(s_im)};
          loc2          <= in_location;
          r2_re         <= reduce(d_re);
          r2_im         <= reduce(d_im);
        end
      end
      if (state == S_OUT0 && out_ready) begin
        out_location  <= loc2;
        out_amplitude <= {r2_re, r2_im};
      end
      if (state == S_OUT1 && out_ready) pair_count <= pair_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_cofactor_pair.sv
// Directed bench for alu_cofactor_pair at complex_bit=8, num_qubit=3, toggle_qubit=0.
module tb_alu_cofactor_pair;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  toggle_qubit;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_location;
  logic [7:0]  in_alpha;
  logic [15:0] in_amplitude;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_location;
  logic [15:0] out_amplitude;
  logic        out_first;
  logic        pair_error;
  logic        overflow;
  logic [15:0] pair_count;

  int checks = 0;
  int errors = 0;

  alu_cofactor_pair #(.complex_bit(8), .num_qubit(3)) dut (
    .clk(clk), .rst(rst), .toggle_qubit(toggle_qubit),
    .in_valid(in_valid), .in_ready(in_ready), .in_location(in_location),
    .in_alpha(in_alpha), .in_amplitude(in_amplitude),
    .out_valid(out_valid), .out_ready(out_ready), .out_location(out_location),
    .out_amplitude(out_amplitude), .out_first(out_first),
    .pair_error(pair_error), .overflow(overflow), .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pk(input int re, input int im);
    logic [7:0] r, i;
    r = re[7:0];
    i = im[7:0];
    return {r, i};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int loc, input int re, input int im, input int k);
    in_valid     = 1'b1;
    in_location  = loc[2:0];
    in_alpha     = k[7:0];
    in_amplitude = pk(re, im);
  endtask

  task automatic send(input int loc, input int re, input int im, input int k);
    drive(loc, re, im, k);
    for (int n = 0; n < 20; n++) begin
      if (in_ready) break;
      step();
    end
    check("send_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int loc, input int re, input int im, input int first);
    for (int n = 0; n < 20; n++) begin
      if (out_valid) break;
      step();
    end
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_loc"}, out_location, loc[2:0]);
    check({tag, "_amp"}, out_amplitude, pk(re, im));
    check({tag, "_first"}, out_first, first[0]);
    step();
  endtask

  initial begin
    rst = 1'b1; toggle_qubit = 2'd0; in_valid = 1'b0; in_location = '0;
    in_alpha = '0; in_amplitude = '0; out_ready = 1'b1;
    step(); step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_loc", out_location, 0);
    check("rst_amp", out_amplitude, 0);
    check("rst_first", out_first, 0);
    check("rst_flags", {pair_error, overflow}, 0);
    check("rst_count", pair_count, 0);
    rst = 1'b0;

    // Basic pair
    send(2, 10, 5, 0);
    send(3, 2, 3, 1);
    expect_out("basic_r1", 2, 7, 7, 1);
    expect_out("basic_r2", 3, 13, 3, 0);
    check("basic_count", pair_count, 1);
    check("basic_idle", out_valid, 0);
    check("basic_flags", {pair_error, overflow}, 0);

    // Overflow
    send(4, 100, 0, 0);
    send(5, 100, 0, 0);
    check("ovf_flag", overflow, 1);
`ifdef COFACTOR_SAT_EN
    expect_out("ovf_r1", 4, 127, 0, 1);
`else
    expect_out("ovf_r1", 4, -56, 0, 1);
`endif
    expect_out("ovf_r2", 5, 0, 0, 0);
    check("ovf_count", pair_count, 2);

    // Location mismatch, then a legal pair (k=2, k=3)
    send(0, 1, 1, 0);
    send(2, 1, 1, 0);
    check("mm_err", pair_error, 1);
    check("mm_noout0", out_valid, 0);
    step();
    check("mm_noout1", out_valid, 0);
    check("mm_count", pair_count, 2);
    send(6, 1, 2, 2);
    send(7, 3, 4, 3);
    expect_out("mm_r1", 6, 3, -5, 1);
    expect_out("mm_r2", 7, -5, 1, 0);
    check("mm_count2", pair_count, 3);

    // Backpressure in S_OUT0
    out_ready = 1'b0;
    send(0, 20, -10, 1);
    send(1, 5, 5, 0);
    drive(2, 9, 9, 0);
    for (int n = 0; n < 5; n++) begin
      check("bp_vld", out_valid, 1);
      check("bp_amp", out_amplitude, pk(15, 25));
      check("bp_rdy", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    expect_out("bp_r1", 0, 15, 25, 1);
    expect_out("bp_r2", 1, 5, 15, 0);
    check("bp_count", pair_count, 4);

    // Overlap: next original accepted alongside r2
    drive(2, 1, 1, 0);
    check("ov_rdyA", in_ready, 1);
    step();
    drive(3, 2, 0, 0);
    step();
    drive(4, 0, 3, 0);
    check("ov_r1_vld", out_valid, 1);
    check("ov_r1_amp", out_amplitude, pk(3, 1));
    check("ov_r1_first", out_first, 1);
    check("ov_r1_rdy", in_ready, 0);
    step();
    check("ov_r2_loc", out_location, 3);
    check("ov_r2_amp", out_amplitude, pk(-1, 1));
    check("ov_r2_first", out_first, 0);
    check("ov_r2_rdy", in_ready, 1);
    step();
    check("ov_dup_vld", out_valid, 0);
    check("ov_dup_rdy", in_ready, 1);
    check("ov_count5", pair_count, 5);
    drive(5, 1, 1, 0);
    step();
    in_valid = 1'b0;
    check("ov_c_loc", out_location, 4);
    check("ov_c_amp", out_amplitude, pk(1, 4));
    step();
    check("ov_d_loc", out_location, 5);
    check("ov_d_amp", out_amplitude, pk(-1, 2));
    step();
    check("ov_count6", pair_count, 6);
    check("ov_idle", out_valid, 0);

    // Reset mid-pair
    send(0, 7, 7, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_flags", {pair_error, overflow}, 0);
    check("mr_count", pair_count, 0);
    check("mr_vld", out_valid, 0);
    send(1, 1, 1, 0);
    check("mr_noout0", out_valid, 0);
    step();
    check("mr_noout1", out_valid, 0);
    send(0, 2, 2, 0);
    expect_out("mr_r1", 1, 3, 3, 1);
    expect_out("mr_r2", 0, -1, -1, 0);
    check("mr_count1", pair_count, 1);
    check("mr_flags2", {pair_error, overflow}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_cofactor_pair.md
# alu_cofactor_pair

Streaming cofactor ALU that pairs an original-phase amplitude with its duplicate-toggle partner and produces both updated amplitudes. It uses a valid/ready handshake on both sides, checks that the two locations form a legal pair, and holds both results in a buffer so the amplitude memory write port can stall it. It sits between the amplitude memory read path and the write-back port of the emulation datapath, and is the successor to the fixed-cadence cofactor ALU.

## Interface
- complex_bit, 24, width of each real/imag component (two's complement)
- num_qubit, 3, amplitude location width
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  reset, synchronous, active-high
- toggle_qubit  in  $clog2(num_qubit) (min 1)  qubit index toggled between pair members; must be stable while a pair is in flight
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_location  in  num_qubit  amplitude location
- in_alpha  in  8  [1:0] phase k (multiply by i^k); [2] zero coefficient; [7:3] reserved, ignored
- in_amplitude  in  2*complex_bit  {real[2cb-1:cb], imag[cb-1:0]}
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- out_location  out  num_qubit  write location
- out_amplitude  out  2*complex_bit  result, same packing
- out_first  out  1  1 = original-phase result, 0 = duplicate result
- pair_error  out  1  sticky: a location mismatch was detected
- overflow  out  1  sticky: a component sum or negation exceeded complex_bit
- pair_count  out  16  completed pairs (both results consumed); wraps at 2^16

## Operation
- FSM states: S_ORIG, S_DUP, S_OUT0, S_OUT1.
- S_ORIG: in_ready=1. On accept, register the location L1 and the product p1; go to S_DUP.
- S_DUP: in_ready=1. On accept, check the location L2 against L1 ^ (1<<toggle_qubit).
  - On a mismatch, set pair_error, discard the pair (no output) and go to S_ORIG.
  - On a match, register r1=p1+p2 at L1 and r2=p1-p2 at L2, then go to S_OUT0.
- S_OUT0: out_valid=1, out_first=1, output r1 at L1. in_ready=0. Go to S_OUT1 on out_ready.
- S_OUT1: out_valid=1, out_first=0, output r2 at L2.
  - in_ready = out_ready.
  - On out_ready, increment pair_count.
  - If in_valid is also high, the accepted beat is the next original: go to S_DUP. Otherwise go to S_ORIG.
- Product p = i^k·a, formed per component:
  - k=0: (re, im)
  - k=1: (-im, re)
  - k=2: (-re, -im)
  - k=3: (im, -re)
  - alpha[2]=1 forces p=(0,0).
- Negation and sum widths:
  - Negation is computed at complex_bit+1 bits.
  - Sums and differences are computed at complex_bit+2 bits, then reduced to complex_bit (see Configuration).
  - overflow is set whenever the reduced value differs from the full-precision value.
- Reset (rst=1 at a clock edge) from any state, including mid-pair:
  - state=S_ORIG, in_ready=1, out_valid=0.
  - out_location, out_amplitude and out_first = 0.
  - pair_error=0, overflow=0, pair_count=0.
  - Any partial pair and any buffered results are discarded.

## Timing
- Earliest sequence: original accepted at cycle t, duplicate at t+1, r1 valid from t+2, r2 valid from t+3 (with out_ready held high).
- Sustained throughput is one pair per 3 cycles, because the next original overlaps the S_OUT1 handshake.
- Outputs are registered and held stable while out_valid=1 and out_ready=0.
- in_ready depends combinationally on out_ready in S_OUT1 only.
- pair_error and overflow update on the cycle after the beat that causes them.

## Configuration
- COFACTOR_SAT_EN defined: reduced components saturate to [-2^(cb-1), 2^(cb-1)-1], including the negation of -2^(cb-1).
- COFACTOR_SAT_EN undefined: reduced components wrap by keeping the low complex_bit bits (two's complement).
- overflow reporting is identical in both builds.

## Test plan
All scenarios use cb=8, num_qubit=3, toggle_qubit=0.
- Basic pair: orig L=2, (10,5), k=0; dup L=3, (2,3), k=1 → r1 at 2 = (7,7), out_first=1; then r2 at 3 = (13,3); pair_count=1.
- Overflow: orig (100,0) k0 + dup (100,0) k0 → r1.re = -56 without the macro, 127 with it; overflow=1; r2=(0,0).
- Mismatch: orig L=0, dup L=2 → no out_valid, pair_error=1; the next two beats form a legal pair normally.
- Backpressure: out_ready=0 for 5 cycles in S_OUT0 → r1 held stable, in_ready=0; release → r1 then r2 delivered in order.
- Overlap: back-to-back legal pairs with out_ready=1 → 3-cycle pair cadence, next original accepted in the same cycle as r2.
- Reset mid-pair: accept orig, assert rst one cycle, then send one beat → that beat is treated as an original (state S_DUP), no output appears, all flags are 0.
